// File: rtl/tube_pkg.sv
// Shared constants and types for the tube number generator and its key front-end.
package tube_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [7:0]  MAX_VALUE_DEFAULT    = 8'd99;
    localparam logic [24:0] TICK_DIV_DEFAULT     = 25'd25_000_000;
    localparam logic [19:0] DEBOUNCE_CNT_DEFAULT = 20'd1_000_000;

    // Modulo (max_value+1) step in either direction; value never exceeds max_value.
    function automatic logic [7:0] next_count(input logic [7:0] value,
                                              input dir_t       dir,
                                              input logic [7:0] max_value);
        logic [7:0] result;
        if (dir == DIR_UP)
            result = (value == max_value) ? 8'd0 : value + 8'd1;
        else
            result = (value == 8'd0) ? max_value : value - 8'd1;
        return result;
    endfunction

endpackage

// File: rtl/tube_number_gen_key_debounce.sv
// Button front-end: 2-flop synchroniser, optional debounce (TUBE_KEY_DEBOUNCE_EN),
// and a one-cycle press pulse on the accepted level falling 1->0.
module key_debounce
    import tube_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic stable;
    logic stable_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
        end
    end

`ifdef TUBE_KEY_DEBOUNCE_EN
    logic [19:0] stable_cnt;

    // A new level is accepted only after it has differed from the stable level
    // for DEBOUNCE_CNT consecutive cycles; any return to the old level restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable     <= 1'b1;
            stable_cnt <= 20'd0;
        end else if (sync_2 == stable) begin
            stable_cnt <= 20'd0;
        end else if (stable_cnt == DEBOUNCE_CNT - 20'd1) begin
            stable     <= sync_2;
            stable_cnt <= 20'd0;
        end else begin
            stable_cnt <= stable_cnt + 20'd1;
        end
    end
`else
    assign stable = sync_2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d <= 1'b1;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end

endmodule

// File: rtl/tube_number_gen.sv
// Modulo-(MAX_VALUE+1) up/down counter feeding Digital_Tube, paced by a prescaler tick,
// with pause and direction buttons. Key debounce is enabled by TUBE_KEY_DEBOUNCE_EN.
module tube_number_gen
    import tube_pkg::*;
#(
    parameter logic [24:0] TICK_DIV     = TICK_DIV_DEFAULT,
    parameter logic [19:0] DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT,
    parameter logic [7:0]  MAX_VALUE    = MAX_VALUE_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Key_Pause_N,
    input  logic       Key_Dir_N,
    output logic [7:0] Number_Data,
    output logic       Update_Sig,
    output logic       Run_Sig
);

    logic        pause_evt;
    logic        dir_evt;
    logic [24:0] prescaler;
    logic        tick;
    dir_t        dir;

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_pause (
        .clk   (CLK),
        .rst   (RST),
        .key_n (Key_Pause_N),
        .press (pause_evt)
    );

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_dir (
        .clk   (CLK),
        .rst   (RST),
        .key_n (Key_Dir_N),
        .press (dir_evt)
    );

    assign tick = Run_Sig && (prescaler == TICK_DIV - 25'd1);

    // A tick coinciding with a pause or direction event still uses the old
    // run/direction state; the toggles take effect from the following cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler   <= 25'd0;
            Number_Data <= 8'd0;
            Update_Sig  <= 1'b0;
            Run_Sig     <= 1'b1;
            dir         <= DIR_UP;
        end else begin
            Update_Sig <= 1'b0;

            if (Run_Sig && !pause_evt) begin
                if (tick)
                    prescaler <= 25'd0;
                else
                    prescaler <= prescaler + 25'd1;
            end else begin
                prescaler <= 25'd0;
            end

            if (tick) begin
                Number_Data <= next_count(Number_Data, dir, MAX_VALUE);
                Update_Sig  <= 1'b1;
            end

            if (pause_evt)
                Run_Sig <= ~Run_Sig;

            if (dir_evt)
                dir <= (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
        end
    end

endmodule

// File: tb/tb_tube_number_gen.sv
// Directed self-checking bench for tube_number_gen (TICK_DIV=10, DEBOUNCE_CNT=4, MAX_VALUE=99);
// key latency and glitch expectations follow TUBE_KEY_DEBOUNCE_EN.
module tb_tube_number_gen;
    import tube_pkg::*;

    localparam logic [24:0] TD = 25'd10;
    localparam logic [19:0] DC = 20'd4;
    localparam logic [7:0]  MV = 8'd99;
`ifdef TUBE_KEY_DEBOUNCE_EN
    localparam int KEY_LAT = 8;
    localparam bit DB      = 1'b1;
`else
    localparam int KEY_LAT = 4;
    localparam bit DB      = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_pause_n = 1'b1;
    logic       key_dir_n = 1'b1;
    logic [7:0] number_data;
    logic       update_sig;
    logic       run_sig;

    int   total = 0;
    int   bad = 0;
    logic [7:0] exp_val;
    dir_t exp_dir;

    tube_number_gen #(.TICK_DIV(TD), .DEBOUNCE_CNT(DC), .MAX_VALUE(MV)) dut (
        .CLK         (clk),
        .RST         (rst),
        .Key_Pause_N (key_pause_n),
        .Key_Dir_N   (key_dir_n),
        .Number_Data (number_data),
        .Update_Sig  (update_sig),
        .Run_Sig     (run_sig)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] v, input dir_t d);
        if (d == DIR_UP)
            return (v == MV) ? 8'd0 : v + 8'd1;
        else
            return (v == 8'd0) ? MV : v - 8'd1;
    endfunction

    function automatic dir_t flip(input dir_t d);
        return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
    endfunction

    task automatic step_tick(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!update_sig && n < 200);
        if (!update_sig)
            check_output({tag, "_timeout"}, 0, 1);
        exp_val = model_next(exp_val, exp_dir);
        check_output(tag, number_data, exp_val);
    endtask

    task automatic run_to(input logic [7:0] target);
        int n;
        int iter = 0;
        do begin
            step_tick("run", n);
            iter++;
        end while (exp_val != target && iter < 150);
    endtask

    task automatic apply_stimulus(input bit pause, input bit dir);
        if (pause) key_pause_n = 1'b0;
        if (dir)   key_dir_n = 1'b0;
        repeat (6) @(negedge clk);
        key_pause_n = 1'b1;
        key_dir_n   = 1'b1;
        if (dir) exp_dir = flip(exp_dir);
    endtask

    initial begin
        int n;
        int upd_cnt;
        int run_at;

        repeat (3) @(negedge clk);
        check_output("rst_data", number_data, 0);
        check_output("rst_update", update_sig, 0);
        check_output("rst_run", run_sig, 1);
        rst = 1'b0;
        exp_val = 8'd0;
        exp_dir = DIR_UP;

        for (int i = 0; i < 3; i++) begin
            step_tick("free_val", n);
            check_output("free_period", n, 10);
        end
        check_output("free_third", number_data, 3);

        run_to(8'd99);
        step_tick("up_wrap", n);
        check_output("up_wrap_zero", number_data, 0);

        run_to(8'd2);
        apply_stimulus(1'b0, 1'b1);
        step_tick("down_a", n);
        check_output("down_1", number_data, 1);
        step_tick("down_b", n);
        check_output("down_0", number_data, 0);
        step_tick("down_c", n);
        check_output("down_wrap_99", number_data, 99);

        key_dir_n = 1'b0;
        repeat (2) @(negedge clk);
        key_dir_n = 1'b1;
        if (!DB) exp_dir = flip(exp_dir);
        step_tick("glitch", n);
        check_output("glitch_val", number_data, DB ? 98 : 0);

        apply_stimulus(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_output("pause_run", run_sig, 0);
        upd_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (update_sig) upd_cnt++;
        end
        check_output("pause_no_update", upd_cnt, 0);
        check_output("pause_hold", number_data, exp_val);

        key_pause_n = 1'b0;
        n = 0;
        run_at = -1;
        do begin
            @(negedge clk);
            n++;
            if (n == 6) key_pause_n = 1'b1;
            if (run_sig && run_at < 0) run_at = n;
        end while (!update_sig && n < 100);
        key_pause_n = 1'b1;
        check_output("resume_run_lat", run_at, KEY_LAT);
        check_output("resume_tick_lat", n, KEY_LAT + 10);
        exp_val = model_next(exp_val, exp_dir);
        check_output("resume_val", number_data, exp_val);

        if (exp_dir != DIR_UP) apply_stimulus(1'b0, 1'b1);
        run_to(8'd5);
        repeat (10 - KEY_LAT) @(negedge clk);
        key_dir_n = 1'b0;
        fork
            begin
                repeat (6) @(negedge clk);
                key_dir_n = 1'b1;
            end
        join_none
        step_tick("sim_tick", n);
        check_output("sim_old_dir", number_data, 6);
        exp_dir = flip(exp_dir);
        step_tick("sim_next", n);
        check_output("sim_new_dir", number_data, 5);

        apply_stimulus(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check_output("both_paused", run_sig, 0);
        check_output("both_hold", number_data, 5);
        apply_stimulus(1'b1, 1'b0);
        step_tick("both_resume", n);
        check_output("both_dir_up", number_data, 6);

        run_to(8'd42);
        key_dir_n = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        key_dir_n = 1'b1;
        @(negedge clk);
        key_dir_n = 1'b0;
        @(negedge clk);
        key_dir_n = 1'b1;
        check_output("midrst_data", number_data, 0);
        check_output("midrst_update", update_sig, 0);
        check_output("midrst_run", run_sig, 1);
        rst = 1'b0;
        exp_val = 8'd0;
        exp_dir = DIR_UP;
        step_tick("midrst_first", n);
        check_output("midrst_period", n, 10);
        check_output("midrst_up", number_data, 1);
        step_tick("midrst_second", n);
        check_output("midrst_run_after", run_sig, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
